// File: rtl/lcd_bus_timer_pkg.sv
// Shared types, timing defaults and command classification for the LCD bus timer.
// Optional busy-flag polling is enabled by defining LCD_BUSY_POLL_EN.
package lcd_bus_timer_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_PSETUP,
    ST_PPULSE,
    ST_PHOLD
  } lcd_state_e;

  localparam int unsigned PWRUP_CYC_DEF      = 750000;
  localparam int unsigned SETUP_CYC_DEF      = 4;
  localparam int unsigned PULSE_CYC_DEF      = 25;
  localparam int unsigned HOLD_CYC_DEF       = 2;
  localparam int unsigned EXEC_SHORT_CYC_DEF = 2000;
  localparam int unsigned EXEC_LONG_CYC_DEF  = 80000;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e, input int unsigned f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/lcd_bus_timer_if.sv
// Command handshake from the sequencer plus the HD44780 pin bundle.
// master = sequencer/board side, slave = lcd_bus_timer.
interface lcd_bus_timer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;
  logic [7:0] lcd_db_in;
  logic       poll_timeout;

  modport master (
    output cmd_valid, cmd_rs, cmd_data, lcd_db_in,
    input  cmd_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_db_out, lcd_db_oe, poll_timeout
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, lcd_db_in,
    output cmd_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_db_out, lcd_db_oe, poll_timeout
  );
endinterface

// File: rtl/lcd_bus_timer_delay_cnt.sv
// Loadable down-counter that saturates at zero; one instance times every FSM state.
// Reset loads RST_VAL so the power-up wait starts straight out of reset.
module lcd_delay_cnt #(
  parameter int unsigned   CW      = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_timer.sv
// HD44780 write-cycle timer: one byte per handshake, with setup/pulse/hold/exec timing.
// Define LCD_BUSY_POLL_EN to replace the fixed exec wait by busy-flag polling.
module lcd_bus_timer
  import lcd_bus_timer_pkg::*;
#(
  parameter int unsigned PWRUP_CYC      = PWRUP_CYC_DEF,
  parameter int unsigned SETUP_CYC      = SETUP_CYC_DEF,
  parameter int unsigned PULSE_CYC      = PULSE_CYC_DEF,
  parameter int unsigned HOLD_CYC       = HOLD_CYC_DEF,
  parameter int unsigned EXEC_SHORT_CYC = EXEC_SHORT_CYC_DEF,
  parameter int unsigned EXEC_LONG_CYC  = EXEC_LONG_CYC_DEF
) (
  input logic            clk,
  input logic            rst_n,
  lcd_bus_timer_if.slave bus
);

  localparam int unsigned CW = $clog2(max_cyc(PWRUP_CYC, SETUP_CYC, PULSE_CYC, HOLD_CYC,
                                              EXEC_SHORT_CYC, EXEC_LONG_CYC)) + 1;

  // Counter reload values: a state lasting N cycles starts its count at N-1.
  localparam logic [CW-1:0] LD_PWRUP = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_SHORT = CW'(EXEC_SHORT_CYC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(EXEC_LONG_CYC - 1);

  lcd_state_e    state_q;
  logic          cmd_ready_q;
  logic          lcd_en_q;
  logic          lcd_rs_q;
  logic          lcd_rw_q;
  logic          lcd_db_oe_q;
  logic [7:0]    lcd_db_q;

  logic          cnt_load_d;
  logic [CW-1:0] cnt_val_d;
  logic          cnt_zero;
  logic          accept;

  assign accept = bus.cmd_valid & cmd_ready_q;

`ifdef LCD_BUSY_POLL_EN
  logic [CW-1:0] poll_cnt_q;
  logic          poll_busy_q;
  logic          poll_timeout_q;
  logic          poll_expired;

  assign poll_expired = (poll_cnt_q == CW'(EXEC_LONG_CYC));
`endif

  always_comb begin
    cnt_load_d = 1'b0;
    cnt_val_d  = '0;
    case (state_q)
      ST_IDLE:  if (accept)   begin cnt_load_d = 1'b1; cnt_val_d = LD_SETUP; end
      ST_SETUP: if (cnt_zero) begin cnt_load_d = 1'b1; cnt_val_d = LD_PULSE; end
      ST_PULSE: if (cnt_zero) begin cnt_load_d = 1'b1; cnt_val_d = LD_HOLD;  end
      ST_HOLD: if (cnt_zero) begin
        cnt_load_d = 1'b1;
`ifdef LCD_BUSY_POLL_EN
        cnt_val_d  = LD_SETUP;
`else
        cnt_val_d  = is_long_cmd(lcd_rs_q, lcd_db_q) ? LD_LONG : LD_SHORT;
`endif
      end
`ifdef LCD_BUSY_POLL_EN
      ST_PSETUP: if (cnt_zero) begin cnt_load_d = 1'b1; cnt_val_d = LD_PULSE; end
      ST_PPULSE: if (cnt_zero) begin cnt_load_d = 1'b1; cnt_val_d = LD_HOLD;  end
      ST_PHOLD:  if (cnt_zero && poll_busy_q) begin cnt_load_d = 1'b1; cnt_val_d = LD_SETUP; end
`endif
      default: ;
    endcase
  end

  lcd_delay_cnt #(
    .CW      (CW),
    .RST_VAL (LD_PWRUP)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_d),
    .load_val_i (cnt_val_d),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_PWRUP;
      cmd_ready_q    <= 1'b0;
      lcd_en_q       <= 1'b0;
      lcd_rs_q       <= 1'b0;
      lcd_rw_q       <= 1'b0;
      lcd_db_oe_q    <= 1'b1;
      lcd_db_q       <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
      poll_cnt_q     <= '0;
      poll_busy_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef LCD_BUSY_POLL_EN
      poll_timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_PWRUP: if (cnt_zero) begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        ST_IDLE: if (accept) begin
          state_q     <= ST_SETUP;
          cmd_ready_q <= 1'b0;
          lcd_rs_q    <= bus.cmd_rs;
          lcd_db_q    <= bus.cmd_data;
          lcd_rw_q    <= 1'b0;
          lcd_db_oe_q <= 1'b1;
        end
        ST_SETUP: if (cnt_zero) begin
          state_q  <= ST_PULSE;
          lcd_en_q <= 1'b1;
        end
        ST_PULSE: if (cnt_zero) begin
          state_q  <= ST_HOLD;
          lcd_en_q <= 1'b0;
        end
        ST_HOLD: if (cnt_zero) begin
`ifdef LCD_BUSY_POLL_EN
          // Switch the bus to a busy-flag read: rs=0, rw=1, pads released.
          state_q     <= ST_PSETUP;
          lcd_rs_q    <= 1'b0;
          lcd_rw_q    <= 1'b1;
          lcd_db_oe_q <= 1'b0;
          poll_cnt_q  <= '0;
          poll_busy_q <= 1'b0;
`else
          state_q <= ST_EXEC;
`endif
        end
        ST_EXEC: if (cnt_zero) begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
`ifdef LCD_BUSY_POLL_EN
        ST_PSETUP, ST_PPULSE, ST_PHOLD: begin
          if (poll_expired) begin
            state_q        <= ST_IDLE;
            cmd_ready_q    <= 1'b1;
            lcd_en_q       <= 1'b0;
            lcd_rw_q       <= 1'b0;
            lcd_db_oe_q    <= 1'b1;
            poll_timeout_q <= 1'b1;
          end else begin
            poll_cnt_q <= poll_cnt_q + CW'(1);
            if (cnt_zero) begin
              case (state_q)
                ST_PSETUP: begin
                  state_q  <= ST_PPULSE;
                  lcd_en_q <= 1'b1;
                end
                ST_PPULSE: begin
                  // Busy flag is captured on the last en-high cycle.
                  state_q     <= ST_PHOLD;
                  lcd_en_q    <= 1'b0;
                  poll_busy_q <= bus.lcd_db_in[7];
                end
                default: begin
                  if (poll_busy_q) begin
                    state_q <= ST_PSETUP;
                  end else begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    lcd_rw_q    <= 1'b0;
                    lcd_db_oe_q <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
`endif
        default: begin
          state_q     <= ST_PWRUP;
          cmd_ready_q <= 1'b0;
          lcd_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = ~cmd_ready_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = lcd_rw_q;
  assign bus.lcd_en     = lcd_en_q;
  assign bus.lcd_db_out = lcd_db_q;
  assign bus.lcd_db_oe  = lcd_db_oe_q;
`ifdef LCD_BUSY_POLL_EN
  assign bus.poll_timeout = poll_timeout_q;
`else
  assign bus.poll_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_timer.sv
// Self-checking bench for lcd_bus_timer with shortened timing; expected waveforms are
// derived per transaction from the cycle offsets after accept.
module tb_lcd_bus_timer;

  localparam int PW = 20;
  localparam int S  = 2;
  localparam int P  = 5;
  localparam int H  = 2;
  localparam int ES = 10;
  localparam int EL = 40;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  lcd_bus_timer_if bus ();

  lcd_bus_timer #(
    .PWRUP_CYC      (PW),
    .SETUP_CYC      (S),
    .PULSE_CYC      (P),
    .HOLD_CYC       (H),
    .EXEC_SHORT_CYC (ES),
    .EXEC_LONG_CYC  (EL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  // Power-up window after reset release: ready low and no strobe for PW cycles.
  task automatic check_pwrup(input string tag);
    for (int i = 1; i <= PW + 1; i++) begin
      n_cmp++;
      if (i <= PW) begin
        if (bus.cmd_ready !== 1'b0 || bus.lcd_en !== 1'b0 || bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_pwrup cyc %0d: got ready=%b en=%b busy=%b required 0 0 1",
                   tag, i, bus.cmd_ready, bus.lcd_en, bus.busy);
        end
        @(negedge clk);
      end else if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_ready cyc %0d: got ready=%b busy=%b required 1 0",
                 tag, i, bus.cmd_ready, bus.busy);
      end
    end
    bus.cmd_valid = 1'b0;
    $display("txn %s: power-up window checked", tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_db_oe, bus.poll_timeout} !== 6'b000010
        || bus.lcd_db_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b en=%b rs=%b rw=%b oe=%b to=%b db=%02h required 0 0 0 0 1 0 00",
               bus.cmd_ready, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_db_oe,
               bus.poll_timeout, bus.lcd_db_out);
    end
    rst_n = 1'b1;
    check_pwrup("reset");
  endtask

  // One accepted byte; every cycle up to ready-again is compared with the expected timeline.
  task automatic run_txn(input logic rs, input logic [7:0] d, input bit junk);
    int          w = 0;
    int          exec_cyc;
    int          tail;
    int          t_end;
    int          u;
    bit          is_long;
    logic [4:0]  exp_ctl;
    logic [4:0]  got_ctl;
    logic        exp_rs;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: got ready=%b required 1 within 200 cycles", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    is_long  = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    exec_cyc = is_long ? EL : ES;
`ifdef LCD_BUSY_POLL_EN
    tail = S + P + H;
`else
    tail = exec_cyc;
`endif
    t_end = 1 + S + P + H + tail;
    @(posedge clk);
    @(negedge clk);
    for (int t = 1; t <= t_end; t++) begin
      if (junk && t < t_end) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = 1'($urandom);
        bus.cmd_data  = 8'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      // exp_ctl = {busy, ready, en, rw, oe}
      if (t == t_end) begin
        exp_ctl = 5'b01001;
      end else if (t <= S + P + H) begin
        exp_ctl = {2'b10, (t >= S + 1 && t <= S + P), 2'b01};
      end else begin
`ifdef LCD_BUSY_POLL_EN
        u = t - (S + P + H);
        exp_ctl = {2'b10, (u >= S + 1 && u <= S + P), 2'b10};
`else
        u = 0;
        exp_ctl = 5'b10001;
`endif
      end
      got_ctl = {bus.busy, bus.cmd_ready, bus.lcd_en, bus.lcd_rw, bus.lcd_db_oe};
      n_cmp++;
      if (got_ctl !== exp_ctl) begin
        n_bad++;
        $display("FAIL ctl rs=%b d=%02h t=%0d: got busy/rdy/en/rw/oe=%b required %b",
                 rs, d, t, got_ctl, exp_ctl);
      end
      if (t <= S + P + H) begin
        n_cmp++;
        if (bus.lcd_rs !== rs || bus.lcd_db_out !== d) begin
          n_bad++;
          $display("FAIL bus rs=%b d=%02h t=%0d: got rs=%b db=%02h required %b %02h",
                   rs, d, t, bus.lcd_rs, bus.lcd_db_out, rs, d);
        end
      end else if (t < t_end) begin
`ifdef LCD_BUSY_POLL_EN
        exp_rs = 1'b0;
`else
        exp_rs = rs;
`endif
        n_cmp++;
        if (bus.lcd_rs !== exp_rs) begin
          n_bad++;
          $display("FAIL exec_rs d=%02h t=%0d: got rs=%b required %b", d, t, bus.lcd_rs, exp_rs);
        end
      end
      if (t < t_end) @(negedge clk);
    end
    $display("txn rs=%b data=%02h long=%0d ready_after=%0d", rs, d, is_long, t_end);
  endtask

  task automatic test_write_data();
    run_txn(1'b1, 8'h41, 1'b0);
  endtask

  task automatic test_exec_length();
    run_txn(1'b0, 8'h01, 1'b0);
    run_txn(1'b0, 8'h38, 1'b0);
    run_txn(1'b0, 8'h04, 1'b0);
    run_txn(1'b0, 8'h02, 1'b0);
    run_txn(1'b1, 8'h01, 1'b0);
    run_txn(1'b0, 8'h03, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), 8'($urandom), 1'b1);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      run_txn(1'($urandom), d, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (S + 2) @(negedge clk);
    n_cmp++;
    if (bus.lcd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pulse_en: got en=%b required 1", bus.lcd_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_db_oe} !== 5'b00001
        || bus.lcd_db_out !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_values: got rdy=%b en=%b rs=%b rw=%b oe=%b db=%02h required 0 0 0 0 1 00",
               bus.cmd_ready, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_db_oe, bus.lcd_db_out);
    end
    rst_n = 1'b1;
    check_pwrup("abort");
  endtask

`ifdef LCD_BUSY_POLL_EN
  task automatic poll_start();
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (S + P + H) @(negedge clk);
  endtask

  task automatic test_poll_busy();
    int pulses = 0;
    bit en_prev = 1'b0;
    bit rw_ok = 1'b1;
    int u;
    bus.lcd_db_in = 8'h80;
    poll_start();
    for (u = 1; u <= 200; u++) begin
      if (bus.cmd_ready === 1'b1) break;
      if (bus.lcd_en === 1'b1 && !en_prev) pulses++;
      en_prev = bus.lcd_en;
      if (bus.lcd_rw !== 1'b1 || bus.lcd_db_oe !== 1'b0 || bus.lcd_rs !== 1'b0) rw_ok = 1'b0;
      bus.lcd_db_in = (pulses < 4) ? 8'h80 : 8'h00;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses != 4 || u != 4 * (S + P + H) + 1 || !rw_ok) begin
      n_bad++;
      $display("FAIL poll_busy: got pulses=%0d ready_at=%0d rw_ok=%b required 4 %0d 1",
               pulses, u, rw_ok, 4 * (S + P + H) + 1);
    end
    n_cmp++;
    if (bus.lcd_rw !== 1'b0 || bus.lcd_db_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL poll_idle: got rw=%b oe=%b required 0 1", bus.lcd_rw, bus.lcd_db_oe);
    end
    bus.lcd_db_in = 8'h00;
    $display("txn poll busy x3: pulses=%0d ready_at=%0d", pulses, u);
  endtask

  task automatic test_poll_timeout();
    int u;
    bit early_ready = 1'b0;
    bus.lcd_db_in = 8'h80;
    poll_start();
    for (u = 1; u <= 300; u++) begin
      if (bus.poll_timeout === 1'b1) break;
      if (bus.cmd_ready === 1'b1) early_ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (u != EL + 2 || bus.cmd_ready !== 1'b1 || early_ready) begin
      n_bad++;
      $display("FAIL poll_timeout: got at=%0d ready=%b early=%b required %0d 1 0",
               u, bus.cmd_ready, early_ready, EL + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.poll_timeout !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_pulse: got to=%b ready=%b required 0 1", bus.poll_timeout, bus.cmd_ready);
    end
    bus.lcd_db_in = 8'h00;
    $display("txn poll stuck: timeout_at=%0d", u);
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.lcd_db_in = 8'h00;
    test_reset();
    test_write_data();
    test_exec_length();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    test_write_data();
`ifdef LCD_BUSY_POLL_EN
    test_poll_busy();
    test_poll_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
